// File: rtl/svc_stream_rr_arb.sv
// Round-robin arbiter merging NUM_SRCS valid/ready streams into one registered output beat.
// Define SVC_STREAM_RR_ARB_PKT_LOCK_EN to hold the grant until a beat with last set.
module svc_stream_rr_arb #(
  parameter int NUM_SRCS   = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRCS-1:0]            s_valid,
  output logic [NUM_SRCS-1:0]            s_ready,
  input  logic [NUM_SRCS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRCS-1:0]            s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_last,
  output logic [ID_WIDTH-1:0]            m_id
);

  logic [ID_WIDTH-1:0]   ptr_reg, ptr_next;
  logic [ID_WIDTH-1:0]   rr_id;
  logic                  rr_found;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [ID_WIDTH-1:0]   sel_inc;
  logic                  out_avail;
  logic                  xfer;

  // First valid source at or after the pointer, wrapping at NUM_SRCS-1.
  always_comb begin : rr_search
    int idx;
    rr_found = 1'b0;
    rr_id    = '0;
    idx      = 0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      idx = (int'(ptr_reg) + k) % NUM_SRCS;
      if (!rr_found && s_valid[idx]) begin
        rr_found = 1'b1;
        rr_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign out_avail = ~m_valid | m_ready;
  assign sel_data  = s_data[sel_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last  = s_last[sel_id];
  assign sel_inc   = (sel_id == ID_WIDTH'(NUM_SRCS - 1)) ? '0 : sel_id + 1'b1;
  // Reset also gates ready so no source sees a handshake while the block is held in reset.
  assign xfer      = sel_valid & out_avail & ~rst;

  for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_ready
    assign s_ready[gi] = xfer & (sel_id == ID_WIDTH'(gi));
  end

`ifdef SVC_STREAM_RR_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t         state_reg, state_next;
  logic [ID_WIDTH-1:0] lock_id_reg, lock_id_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      lock_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
    end
  end

  // While locked only the owner may be granted, even when it is momentarily idle.
  always_comb begin
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    ptr_next     = ptr_reg;
    sel_id       = rr_id;
    sel_valid    = rr_found;
    if (state_reg == LOCKED) begin
      sel_id    = lock_id_reg;
      sel_valid = s_valid[lock_id_reg];
    end
    if (xfer) begin
      if (sel_last) begin
        state_next = IDLE;
        ptr_next   = sel_inc;
      end else begin
        state_next   = LOCKED;
        lock_id_next = sel_id;
      end
    end
  end
`else
  always_comb begin
    sel_id    = rr_id;
    sel_valid = rr_found;
    ptr_next  = ptr_reg;
    if (xfer) begin
      ptr_next = sel_inc;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Output stage: load on transfer, drain on accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_last  <= sel_last;
      m_id    <= sel_id;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
